// File: rtl/sum_frame_pkg.sv
// Shared types and constants for the binary-sum-to-ASCII framer.
// SUM_FRAME_CRLF_EN selects 4-byte frames (digits + CR LF) instead of 2 digits.
package sum_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } frame_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

`ifdef SUM_FRAME_CRLF_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 2;
`endif

    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
        return ASCII_ZERO + {4'h0, digit};
    endfunction

endpackage

// File: rtl/bin2dec_2digit.sv
// Combinational binary (0..63) to two BCD digits using restoring compare-subtract.
// The tens digit is built MSB-first from weights 40, 20, 10, so no divider is needed.
module bin2dec_2digit #(
    parameter int SUM_W = 5
) (
    input  logic [SUM_W-1:0] value,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    logic [6:0] rem [0:2];
    logic [2:0] tens_bits;
    logic [6:0] last_rem;

    assign rem[0] = 7'(value);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stage
            localparam logic [6:0] WEIGHT = 7'(40 >> gi);
            assign tens_bits[2-gi] = (rem[gi] >= WEIGHT);
            assign rem[gi+1]       = tens_bits[2-gi] ? (rem[gi] - WEIGHT) : rem[gi];
        end
    endgenerate

    // Final weight-10 stage: what remains afterwards is always below 10.
    assign tens_bits[0] = (rem[2] >= 7'd10);
    assign last_rem     = tens_bits[0] ? (rem[2] - 7'd10) : rem[2];

    assign tens = {1'b0, tens_bits};
    assign ones = last_rem[3:0];

endmodule

// File: rtl/sum_ascii_framer.sv
// Frames a binary sum as ASCII decimal bytes and hands them to a UART one at a time.
// Define SUM_FRAME_CRLF_EN to append CR LF after the two digits.
module sum_ascii_framer
    import sum_frame_pkg::*;
#(
    parameter int SUM_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             sum_valid,
    output logic             sum_ready,
    input  logic             tx_busy,
    output logic             tx_en,
    output logic [7:0]       tx_data,
    output logic             frame_busy
);

    frame_state_t     state_reg, state_next;
    logic [1:0]       byte_idx_reg, byte_idx_next;
    logic [SUM_W-1:0] sum_reg, sum_next;
    logic             tx_en_reg, tx_en_next;
    logic [7:0]       tx_data_reg, tx_data_next;
    logic             frame_busy_reg;
    logic             sum_ready_reg;

    logic [3:0]       tens;
    logic [3:0]       ones;
    logic [7:0]       cur_byte;
    logic             last_byte;

    bin2dec_2digit #(
        .SUM_W (SUM_W)
    ) u_bin2dec (
        .value (sum_reg),
        .tens  (tens),
        .ones  (ones)
    );

    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx_reg)
            2'd0:    cur_byte = digit_to_ascii(tens);
            2'd1:    cur_byte = digit_to_ascii(ones);
`ifdef SUM_FRAME_CRLF_EN
            2'd2:    cur_byte = ASCII_CR;
            2'd3:    cur_byte = ASCII_LF;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    assign last_byte = (byte_idx_reg == 2'(FRAME_LEN - 1));

    // Each byte is a full busy handshake: strobe, see busy rise, see busy fall.
    always_comb begin
        state_next    = state_reg;
        byte_idx_next = byte_idx_reg;
        sum_next      = sum_reg;
        tx_en_next    = 1'b0;
        tx_data_next  = tx_data_reg;
        case (state_reg)
            IDLE: begin
                if (sum_valid && sum_ready_reg) begin
                    sum_next      = sum_in;
                    byte_idx_next = 2'd0;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                if (!tx_busy) begin
                    tx_en_next   = 1'b1;
                    tx_data_next = cur_byte;
                    state_next   = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_next = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_byte) begin
                        byte_idx_next = 2'd0;
                        state_next    = IDLE;
                    end else begin
                        byte_idx_next = byte_idx_reg + 2'd1;
                        state_next    = ISSUE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they track state_reg
    // exactly, except sum_ready which stays low throughout reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            byte_idx_reg   <= 2'd0;
            sum_reg        <= '0;
            tx_en_reg      <= 1'b0;
            tx_data_reg    <= 8'h00;
            frame_busy_reg <= 1'b0;
            sum_ready_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            byte_idx_reg   <= byte_idx_next;
            sum_reg        <= sum_next;
            tx_en_reg      <= tx_en_next;
            tx_data_reg    <= tx_data_next;
            frame_busy_reg <= (state_next != IDLE);
            sum_ready_reg  <= (state_next == IDLE);
        end
    end

    assign sum_ready  = sum_ready_reg;
    assign tx_en      = tx_en_reg;
    assign tx_data    = tx_data_reg;
    assign frame_busy = frame_busy_reg;

endmodule

// File: tb/tb_sum_ascii_framer.sv
// Directed bench for sum_ascii_framer (SUM_W=6) with a simple UART busy model.
// Expected frame length follows SUM_FRAME_CRLF_EN.
module tb_sum_ascii_framer;

`ifdef SUM_FRAME_CRLF_EN
    localparam int EXP_LEN = 4;
`else
    localparam int EXP_LEN = 2;
`endif
    localparam int BUSY_LEN = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] sum_in = '0;
    logic       sum_valid = 1'b0;
    logic       sum_ready;
    logic       tx_busy;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       frame_busy;

    logic       hold_busy = 1'b0;
    int         busy_cnt = 0;

    int         total = 0;
    int         bad = 0;

    logic [7:0] got [0:15];
    int         strobe_total = 0;
    int         viol_cnt = 0;
    logic       prev_en = 1'b0;

    typedef struct {
        logic [5:0] sum;
        logic [7:0] d0;
        logic [7:0] d1;
    } vec_t;

    vec_t vecs [0:6];

    sum_ascii_framer #(
        .SUM_W (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sum_in     (sum_in),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .tx_busy    (tx_busy),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .frame_busy (frame_busy)
    );

    always #5 clk = ~clk;

    // UART model: busy for BUSY_LEN cycles after each strobe
    always @(posedge clk) begin
        if (tx_en) busy_cnt <= BUSY_LEN;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = hold_busy || (busy_cnt != 0);

    // Byte monitor: record bytes, flag strobes wider than a cycle or during busy
    always @(negedge clk) begin
        prev_en <= tx_en;
        if (tx_en) begin
            got[strobe_total % 16] <= tx_data;
            strobe_total <= strobe_total + 1;
            if (prev_en || tx_busy) viol_cnt <= viol_cnt + 1;
        end
    end

    task automatic chk(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, actual, expected);
        end
    endtask

    task automatic send_sum(input logic [5:0] s);
        int n = 0;
        @(negedge clk);
        while (!sum_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", int'(sum_ready), 1);
        sum_in    = s;
        sum_valid = 1'b1;
        @(negedge clk);
        sum_valid = 1'b0;
        chk("busy_after_accept", int'(frame_busy), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (frame_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_in_time", int'(frame_busy), 0);
    endtask

    task automatic finish_frame(input int base, input int vbase,
                                input logic [7:0] e0, input logic [7:0] e1);
        wait_idle();
        @(negedge clk);
        chk("strobe_count", strobe_total - base, EXP_LEN);
        chk("byte0", int'(got[base % 16]), int'(e0));
        chk("byte1", int'(got[(base + 1) % 16]), int'(e1));
`ifdef SUM_FRAME_CRLF_EN
        chk("byte2_cr", int'(got[(base + 2) % 16]), 8'h0D);
        chk("byte3_lf", int'(got[(base + 3) % 16]), 8'h0A);
`endif
        chk("strobe_violations", viol_cnt - vbase, 0);
        chk("ready_after_frame", int'(sum_ready), 1);
        $display("frame: bytes=%02h %02h strobes=%0d", got[base % 16],
                 got[(base + 1) % 16], strobe_total - base);
    endtask

    task automatic run_frame(input logic [5:0] s, input logic [7:0] e0, input logic [7:0] e1);
        int base;
        int vbase;
        @(negedge clk);
        base  = strobe_total;
        vbase = viol_cnt;
        send_sum(s);
        finish_frame(base, vbase, e0, e1);
    endtask

    initial begin
        int base;
        int vbase;
        int n;

        vecs[0] = '{6'd7,  8'h30, 8'h37};
        vecs[1] = '{6'd31, 8'h33, 8'h31};
        vecs[2] = '{6'd0,  8'h30, 8'h30};
        vecs[3] = '{6'd63, 8'h36, 8'h33};
        vecs[4] = '{6'd10, 8'h31, 8'h30};
        vecs[5] = '{6'd45, 8'h34, 8'h35};
        vecs[6] = '{6'd59, 8'h35, 8'h39};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sum_ready", int'(sum_ready), 0);
        chk("rst_tx_en", int'(tx_en), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_frame_busy", int'(frame_busy), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(sum_ready), 1);
        chk("idle_after_rst", int'(frame_busy), 0);

        for (int i = 0; i < 7; i++) begin
            $display("vector sum=%0d", vecs[i].sum);
            run_frame(vecs[i].sum, vecs[i].d0, vecs[i].d1);
        end

        // Sum offered mid-frame must be dropped
        @(negedge clk);
        base  = strobe_total;
        vbase = viol_cnt;
        send_sum(6'd45);
        repeat (5) @(negedge clk);
        sum_in    = 6'd12;
        sum_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("ready_low_in_frame", int'(sum_ready), 0);
        sum_valid = 1'b0;
        finish_frame(base, vbase, 8'h34, 8'h35);
        repeat (30) @(negedge clk);
        chk("no_extra_frame", strobe_total - base, EXP_LEN);
        chk("still_idle", int'(frame_busy), 0);

        // Downstream busy at acceptance
        @(negedge clk);
        hold_busy = 1'b1;
        base  = strobe_total;
        vbase = viol_cnt;
        send_sum(6'd25);
        repeat (20) @(negedge clk);
        chk("no_strobe_while_busy", strobe_total - base, 0);
        hold_busy = 1'b0;
        @(negedge clk);
        chk("first_byte_latency", int'(tx_en), 1);
        chk("first_byte_data", int'(tx_data), 8'h32);
        finish_frame(base, vbase, 8'h32, 8'h35);

        // Reset during the second byte
        @(negedge clk);
        base = strobe_total;
        send_sum(6'd58);
        n = 0;
        while ((strobe_total - base) < 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("reached_second_byte", strobe_total - base, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_tx_en", int'(tx_en), 0);
        chk("midrst_frame_busy", int'(frame_busy), 0);
        chk("midrst_sum_ready", int'(sum_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("abandoned_frame", strobe_total - base, 2);
        $display("reset mid-frame: strobes=%0d", strobe_total - base);
        run_frame(6'd10, 8'h31, 8'h30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
